// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
`timescale 1ns/1ps
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_PAR   = 3'd5,
        ST_STOP  = 3'd6
    } state_e;

    localparam int WIDTH_DEF        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// Bit-period timer: ticks on the last cycle of every CLKS_PER_BIT period.
`timescale 1ns/1ps
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic restart_i,
    output logic bit_tick_o,
    output logic pre_tick_o
);

    localparam int TW = clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE  = TW'(CLKS_PER_BIT - 2);

    logic [TW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = (cnt_q == LAST);
    assign pre_tick_o = (cnt_q == PRE);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || bit_tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO read port and serialises them as start/data/[parity]/stop frames.
`timescale 1ns/1ps
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int IW = (WIDTH > 1) ? clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, pre_tick, restart, start_ok;

    assign start_ok = en_i && !empty_i;
    assign restart  = (state_d != state_q) || (state_q == ST_IDLE);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_i      (clk_i),
        .clr_i      (clr_i),
        .restart_i  (restart),
        .bit_tick_o (tick),
        .pre_tick_o (pre_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                shift_d = rdata_i;
                par_d   = ^rdata_i;
                state_d = ST_START;
            end
            ST_START: if (tick) begin
                idx_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(WIDTH - 1)) state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
            end
            ST_PAR:   if (tick) state_d = ST_STOP;
            ST_STOP: begin
                // Registered done must land on the final stop cycle, so raise it one cycle early.
                done_d = pre_tick;
                if (tick) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = start_ok ? ST_FETCH : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered line lines up with the state.
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_PAR:   tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        rd_d   = (state_d == ST_FETCH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_o        = tx_q;
    assign rd_en_o     = rd_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: two transmitters (no parity / even parity) fed by behavioural FIFOs, decoded by a mid-bit monitor.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] wr_en = 2'b00;
    logic [1:0] empty = 2'b11;
    logic [1:0] rd_en, tx, busy, done;
    logic [7:0] wr_data [2] = '{8'h00, 8'h00};
    logic [7:0] rdata [2] = '{8'h00, 8'h00};
    logic [15:0] fcnt [2];

    logic [7:0] fq [2][$];
    logic [7:0] exp_q [2][$];
    int frames_exp [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int consec_err [2] = '{0, 0};
    int rd_err [2] = '{0, 0};
    logic [1:0] prev_rd = 2'b00;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .CNT_W(16)) dut0 (
        .clk_i(clk), .clr_i(clr), .en_i(en[0]), .empty_i(empty[0]), .rdata_i(rdata[0]),
        .rd_en_o(rd_en[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]), .frame_cnt_o(fcnt[0])
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .CNT_W(16)) dut1 (
        .clk_i(clk), .clr_i(clr), .en_i(en[1]), .empty_i(empty[1]), .rdata_i(rdata[1]),
        .rd_en_o(rd_en[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]), .frame_cnt_o(fcnt[1])
    );

    initial begin
        #40;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: registered read data, empty flag updated at the same edge as the pop/push.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                if (fq[i].size() == 0) rd_err[i] <= rd_err[i] + 1;
                else rdata[i] <= fq[i].pop_front();
            end
            if (wr_en[i]) fq[i].push_back(wr_data[i]);
            empty[i] <= (fq[i].size() == 0);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && prev_rd[i]) consec_err[i] <= consec_err[i] + 1;
            if (rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            prev_rd[i] <= rd_en[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic fifo_write(input int i, input logic [7:0] d);
        @(negedge clk);
        wr_en[i] = 1'b1;
        wr_data[i] = d;
        @(negedge clk);
        wr_en[i] = 1'b0;
        exp_q[i].push_back(d);
    endtask

    // Waits for a start bit, samples every bit at its centre, then waits for the done pulse.
    task automatic recv(input int i, input int npar, input int drop_after,
                        output logic [7:0] d, output logic p, output int t0,
                        output int len, output bit ok);
        int nb;
        int n;
        logic [10:0] bits;
        nb = 10 + npar;
        bits = '0;
        n = 0;
        ok = 1'b0;
        d = '0;
        p = 1'b0;
        t0 = 0;
        len = 0;
        @(negedge clk);
        while (tx[i] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (tx[i] !== 1'b0) return;
        t0 = cyc;
        for (int c = 1; c <= 2 + CPB * (nb - 1); c++) begin
            @(negedge clk);
            if (c == drop_after) en[i] = 1'b0;
            if (c >= 2 && (c - 2) % CPB == 0) bits[(c - 2) / CPB] = tx[i];
        end
        n = 0;
        while (done[i] !== 1'b1 && n < 2 * CPB) begin
            @(negedge clk);
            n++;
        end
        len = cyc - t0 + 1;
        d = bits[8:1];
        p = (npar != 0) ? bits[9] : 1'b0;
        ok = (bits[0] === 1'b0) && (bits[nb - 1] === 1'b1) && (done[i] === 1'b1);
    endtask

    task automatic test_reset();
        #1 clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #9;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ({tx[i], rd_en[i], busy[i], done[i]} !== 4'b1000 || fcnt[i] !== 16'd0) begin
                    n_bad++;
                    $display("FAIL reset[%0d] t=%0t: tx/rd/busy/done=%b%b%b%b cnt=%0d, want 1000 cnt=0",
                             i, $time, tx[i], rd_en[i], busy[i], done[i], fcnt[i]);
                end
            end
        end
        #5 clr = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] d, e;
        logic p;
        int t0, len, r0, d0;
        bit ok;
        r0 = rd_cnt[0];
        d0 = done_cnt[0];
        fifo_write(0, 8'hA5);
        en[0] = 1'b1;
        recv(0, 0, -1, d, p, t0, len, ok);
        e = exp_q[0].pop_front();
        frames_exp[0]++;
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL single_data: got %h ok=%0d, want %h", d, ok, e);
        end
        n_cmp++;
        if (len != 10 * CPB) begin
            n_bad++;
            $display("FAIL single_len: got %0d, want %0d", len, 10 * CPB);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (rd_cnt[0] - r0 != 1 || done_cnt[0] - d0 != 1) begin
            n_bad++;
            $display("FAIL single_pulses: rd=%0d done=%0d, want 1 and 1", rd_cnt[0] - r0, done_cnt[0] - d0);
        end
        n_cmp++;
        if (fcnt[0] !== 16'(frames_exp[0]) || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: cnt=%0d busy=%b, want %0d busy=0", fcnt[0], busy[0], frames_exp[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        logic p;
        int t0, tprev, len, r0;
        bit ok;
        en[0] = 1'b0;
        for (int k = 0; k < 16; k++) fifo_write(0, 8'($urandom));
        r0 = rd_cnt[0];
        en[0] = 1'b1;
        tprev = 0;
        for (int k = 0; k < 16; k++) begin
            recv(0, 0, -1, d, p, t0, len, ok);
            e = exp_q[0].pop_front();
            frames_exp[0]++;
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL b2b_data[%0d]: got %h ok=%0d, want %h", k, d, ok, e);
            end
            if (k > 0) begin
                n_cmp++;
                if (t0 - tprev != 10 * CPB + 2) begin
                    n_bad++;
                    $display("FAIL b2b_gap[%0d]: start spacing %0d, want %0d", k, t0 - tprev, 10 * CPB + 2);
                end
            end
            tprev = t0;
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (rd_cnt[0] - r0 != 16 || fcnt[0] !== 16'(frames_exp[0]) || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: rd=%0d cnt=%0d busy=%b, want 16 %0d 0",
                     rd_cnt[0] - r0, fcnt[0], busy[0], frames_exp[0]);
        end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [4];
        logic [7:0] d, e;
        logic p;
        int t0, len;
        bit ok;
        bytes[0] = 8'h07;
        bytes[1] = 8'h03;
        bytes[2] = 8'($urandom);
        bytes[3] = 8'($urandom);
        en[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fifo_write(1, bytes[k]);
            recv(1, 1, -1, d, p, t0, len, ok);
            e = exp_q[1].pop_front();
            frames_exp[1]++;
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL par_data[%0d]: got %h ok=%0d, want %h", k, d, ok, e);
            end
            n_cmp++;
            if (p !== 1'($countones(e) % 2)) begin
                n_bad++;
                $display("FAIL par_bit[%0d]: got %b for %h, want %0d", k, p, e, $countones(e) % 2);
            end
            n_cmp++;
            if (len != 11 * CPB) begin
                n_bad++;
                $display("FAIL par_len[%0d]: got %0d, want %0d", k, len, 11 * CPB);
            end
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (fcnt[1] !== 16'(frames_exp[1])) begin
            n_bad++;
            $display("FAIL par_cnt: got %0d, want %0d", fcnt[1], frames_exp[1]);
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] d, e;
        logic p;
        int t0, len, r0;
        bit ok;
        en[0] = 1'b0;
        for (int k = 0; k < 4; k++) fifo_write(0, 8'($urandom));
        r0 = rd_cnt[0];
        en[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            recv(0, 0, (k == 1) ? 1 + CPB + CPB * int'($urandom_range(0, 7)) : -1, d, p, t0, len, ok);
            e = exp_q[0].pop_front();
            frames_exp[0]++;
            n_cmp++;
            if (!ok || d !== e || len != 10 * CPB) begin
                n_bad++;
                $display("FAIL drop_frame[%0d]: got %h ok=%0d len=%0d, want %h len=%0d", k, d, ok, len, e, 10 * CPB);
            end
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (rd_cnt[0] - r0 != 2 || fq[0].size() != 2) begin
            n_bad++;
            $display("FAIL drop_stop: rd=%0d left=%0d, want 2 and 2", rd_cnt[0] - r0, fq[0].size());
        end
        n_cmp++;
        if (fcnt[0] !== 16'(frames_exp[0]) || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_end: cnt=%0d busy=%b, want %0d busy=0", fcnt[0], busy[0], frames_exp[0]);
        end
        en[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            recv(0, 0, -1, d, p, t0, len, ok);
            e = exp_q[0].pop_front();
            frames_exp[0]++;
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL drop_flush[%0d]: got %h ok=%0d, want %h", k, d, ok, e);
            end
        end
    endtask

    task automatic test_clear_midframe();
        logic [7:0] d, e;
        logic p;
        int t0, len, n;
        bit ok;
        en[0] = 1'b1;
        fifo_write(0, 8'h3C);
        n = 0;
        while (tx[0] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (tx[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_start: tx=%b after %0d cycles, want 0", tx[0], n);
        end
        repeat (10) @(negedge clk);
        clr = 1'b1;
        void'(exp_q[0].pop_front());
        frames_exp[0] = 0;
        frames_exp[1] = 0;
        #1;
        n_cmp++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fcnt[0] !== 16'd0 || fcnt[1] !== 16'd0) begin
            n_bad++;
            $display("FAIL clr_now: tx=%b busy=%b cnt0=%0d cnt1=%0d, want 1 0 0 0", tx[0], busy[0], fcnt[0], fcnt[1]);
        end
        @(negedge clk);
        clr = 1'b0;
        fifo_write(0, 8'h81);
        recv(0, 0, -1, d, p, t0, len, ok);
        e = exp_q[0].pop_front();
        frames_exp[0]++;
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL clr_next: got %h ok=%0d, want %h", d, ok, e);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (fcnt[0] !== 16'(frames_exp[0]) || fq[0].size() != 0 || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_end: cnt=%0d left=%0d busy=%b, want %0d 0 0", fcnt[0], fq[0].size(), busy[0], frames_exp[0]);
        end
    endtask

    task automatic test_protocol();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (consec_err[i] != 0 || rd_err[i] != 0 || exp_q[i].size() != 0) begin
                n_bad++;
                $display("FAIL protocol[%0d]: back-to-back rd=%0d empty reads=%0d pending=%0d, want 0 0 0",
                         i, consec_err[i], rd_err[i], exp_q[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_en_drop();
        test_clear_midframe();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
